pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed D->E stage register.
- Carries a configurable payload plus PC/PC+8, exception code and branch-delay flag between any two pipeline stages.
- Replaces the single en-stall with a valid/ready handshake and an optional 2-entry skid buffer, so upstream ready never depends combinationally on downstream ready.
- Keeps the existing reset / bubble (clr) / exception-redirect (req) semantics.

Parameters:
- DATA_W, 160, payload width (instr, ext, RD1, RD2 packed by the instantiating stage).
- PC_W, 32, PC width.
- EXC_W, 5, exception code width.
- SKID, 1, 1 = 2-entry skid buffer; 0 = single register with combinational ready.
- RESET_PC, 32'h0000_3000, PC presented after reset.
- HANDLER_PC, 32'h0000_4180, PC presented after req.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  exception/interrupt redirect: flush stage, present handler PC
- clr  in  1  bubble: incoming beat is kept as a nop carrying its PC and bd
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  DATA_W  payload
- in_pc  in  PC_W  beat PC
- in_exc  in  EXC_W  exception code
- in_bd  in  1  branch-delay-slot flag
- out_valid  out  1  head beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_pc  out  PC_W  head PC
- out_pc8  out  PC_W  out_pc+8, modulo 2^PC_W
- out_exc  out  EXC_W  head exception code
- out_bd  out  1  head bd flag
- occupancy  out  2  number of held beats, 0..2

Behaviour:
- Handshake rules:
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
  - Outputs always reflect the main register. The skid register is never visible directly.
- Priority: reset > req > clr > normal. All effects are synchronous, registered on the next posedge.
- reset:
  - Both entries invalid: out_valid=0, occupancy=0.
  - out_pc=RESET_PC, out_pc8=RESET_PC+8.
  - out_data=0, out_exc=0, out_bd=0.
- req:
  - Both entries discarded, including a simultaneous push. Upstream sees the handshake, but the beat is dropped.
  - out_valid=0, out_pc=HANDLER_PC, out_pc8=HANDLER_PC+8.
  - out_data=0, out_exc=0, out_bd=0.
- clr with push:
  - Beat is stored with data=0 and exc=0. pc and bd come from the input.
  - The stored entry is valid, i.e. it is a nop that still carries its EPC.
  - clr without push has no effect.
- States for SKID=1:
  - EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - in_ready = (state != FULL). This is a registered decode, independent of out_ready.
- Transitions for SKID=1:
  - EMPTY + push -> ONE; main<=in.
  - ONE + push & !pop -> FULL; skid<=in.
  - ONE + push & pop -> ONE; main<=in.
  - ONE + pop & !push -> EMPTY. Main fields hold their values; only valid clears.
  - FULL + pop -> ONE; main<=skid.
  - FULL + !pop -> FULL; all fields hold.
- SKID=0:
  - States are EMPTY/ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - Push into ONE requires a simultaneous pop.
- Latency and throughput:
  - Push to out_valid latency is 1 cycle.
  - Full throughput of 1 beat/cycle when out_ready is held high.
  - No beat is lost or duplicated except by req/reset.
- out_pc8:
  - Computed from the stored pc, with wrap: pc=2^PC_W-4 gives pc8=4.
- Holding fields:
  - When out_valid=0 after a pop, fields keep their last value.
  - After reset/req, fields take the values listed above.
- reset or req mid-transfer overrides any push/pop in the same cycle.

Test Plan:
- Reset with in_valid=1 -> next cycle out_valid=0, out_pc=0x3000, out_pc8=0x3008, occupancy=0, in_ready=1.
- Stream pc 0x3000,0x3004,0x3008 with out_ready=1 -> out_pc matches 1 cycle later each cycle, occupancy=1, in_ready stays 1.
- SKID=1:
  - Push 0x3000, then drop out_ready and push 0x3004 -> occupancy=2, in_ready=0, out_pc=0x3000.
  - Then raise out_ready -> 0x3000 then 0x3004 pop in order, in_ready returns to 1 the cycle after the first pop.
- clr with push of pc=0x3010, bd=1, data=0xFFFF..., exc=4 -> out_valid=1, out_pc=0x3010, out_bd=1, out_data=0, out_exc=0.
- req while FULL and pushing -> next cycle out_valid=0, occupancy=0, out_pc=0x4180, out_pc8=0x4188, out_bd=0. req+reset together -> out_pc=0x3000.
- SKID=0: out_valid=1, out_ready=0 -> in_ready=0 the same cycle. Push with pc=0xFFFFFFFC -> out_pc8=0x00000004.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and an optional 2-entry skid buffer.
// Carries payload, PC (plus PC+8), exception code and branch-delay flag; supports bubble and redirect.
module pipe_stage_skid_reg #(
    parameter int unsigned    DATA_W     = 160,
    parameter int unsigned    PC_W       = 32,
    parameter int unsigned    EXC_W      = 5,
    parameter bit             SKID       = 1'b1,
    parameter logic [PC_W-1:0] RESET_PC   = 'h0000_3000,
    parameter logic [PC_W-1:0] HANDLER_PC = 'h0000_4180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc8,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } beat_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e state_q;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   push;
    logic   pop;

    assign out_valid = (state_q != StEmpty);

    // With the skid buffer, ready depends only on registered state, breaking the ready path.
    assign in_ready = SKID ? (state_q != StFull) : (!out_valid || out_ready);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // A bubbled beat stays valid as a nop but keeps its PC and bd for EPC reporting.
    always_comb begin
        in_beat.data = clr ? '0 : in_data;
        in_beat.pc   = in_pc;
        in_beat.exc  = clr ? '0 : in_exc;
        in_beat.bd   = in_bd;
    end

    always_ff @(posedge clk) begin
        if (reset || req) begin
            state_q      <= StEmpty;
            main_q.data  <= '0;
            main_q.pc    <= reset ? RESET_PC : HANDLER_PC;
            main_q.exc   <= '0;
            main_q.bd    <= 1'b0;
            skid_q       <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_q <= StOne;
                        main_q  <= in_beat;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_q <= in_beat;
                    end else if (push) begin
                        state_q <= StFull;
                        skid_q  <= in_beat;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign out_data  = main_q.data;
    assign out_pc    = main_q.pc;
    assign out_pc8   = main_q.pc + PC_W'(8);
    assign out_exc   = main_q.exc;
    assign out_bd    = main_q.bd;
    assign occupancy = state_q;

endmodule
